// File: rtl/register_file_unit.sv
// register_file_unit: NREG x DW general registers organised as high/low pairs.
// One selected register drives the data bus and one selected pair drives the
// address bus. Registers load singly or as a pair, and a pair can increment in
// place. Bus-contention errors are latched until cleared.
module register_file_unit #(
    parameter  int DW   = 8,
    parameter  int NREG = 8,
    localparam int AW   = 2 * DW,
    localparam int PW   = (NREG / 2 > 1) ? $clog2(NREG / 2) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREG-1:0]      ld_en,
    input  logic [NREG-1:0]      sel_en,
    input  logic [PW-1:0]        pair_idx,
    input  logic                 ld_pair,
    input  logic                 sel_pair,
    input  logic                 inc_pair,
    input  logic [DW-1:0]        data_bus_in,
    output logic [DW-1:0]        data_bus_out,
    output logic                 data_bus_oe,
    input  logic [AW-1:0]        addr_bus_in,
    output logic [AW-1:0]        addr_bus_out,
    output logic                 addr_bus_oe,
    output logic                 inc_wrap,
    output logic                 err_contention,
    input  logic                 err_clear,
    output logic [NREG*DW-1:0]   regs_q
);

    localparam int NPAIR = NREG / 2;

    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];
    logic          inc_wrap_q, inc_wrap_d;
    logic          err_q, err_d;

    logic [AW-1:0] pair_val;
    logic [AW-1:0] pair_inc;
    logic          pair_hit_ld;

    // Decode the selected pair and drive both buses combinationally.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        pair_val     = '0;
        pair_hit_ld  = 1'b0;
        data_bus_out = '0;
        regs_q       = '0;
        // An out-of-range pair index (NREG/2 not a power of two) selects nothing.
        for (int p = 0; p < NPAIR; p++) begin
            if (pair_idx == PW'(p)) begin
                pair_val    = {rf_q[2*p], rf_q[2*p+1]};
                pair_hit_ld = ld_en[2*p] | ld_en[2*p+1];
            end
        end
        pair_inc = pair_val + AW'(1);
        // Scan downwards so the lowest set select bit is the one that wins.
        for (int i = NREG - 1; i >= 0; i--) begin
            if (sel_en[i]) data_bus_out = rf_q[i];
        end
        for (int i = 0; i < NREG; i++) begin
            regs_q[i*DW +: DW] = rf_q[i];
        end
        data_bus_oe  = (|sel_en) & ~reset;
        addr_bus_oe  = sel_pair & ~reset;
        addr_bus_out = sel_pair ? pair_val : '0;
    end

    // Next-state: single loads first, then pair increment, then pair load overrides.
    always_comb begin
        logic multi_sel;
        logic contention;
        logic pair_match;
        pair_match = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = ld_en[i] ? data_bus_in : rf_q[i];
        end
        for (int p = 0; p < NPAIR; p++) begin
            if (pair_idx == PW'(p)) begin
                pair_match = 1'b1;
                if (ld_pair) begin
                    {rf_d[2*p], rf_d[2*p+1]} = addr_bus_in;
                end else if (inc_pair) begin
                    {rf_d[2*p], rf_d[2*p+1]} = pair_inc;
                end
            end
        end
        inc_wrap_d = inc_pair & ~ld_pair & pair_match & (pair_inc == '0);
        multi_sel  = (sel_en & (sel_en - NREG'(1))) != '0;
        contention = multi_sel | (ld_pair & inc_pair)
                   | ((ld_pair | inc_pair) & pair_hit_ld);
        // A new contention event takes precedence over a simultaneous clear.
        if (contention)     err_d = 1'b1;
        else if (err_clear) err_d = 1'b0;
        else                err_d = err_q;
    end

    // State registers; asynchronous reset aborts any pending update.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the register array is reset because software reads it straight after reset; a plain RAM would not be.
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            inc_wrap_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
            inc_wrap_q <= inc_wrap_d;
            err_q      <= err_d;
        end
    end

    assign inc_wrap       = inc_wrap_q;
    assign err_contention = err_q;

endmodule

// File: tb/tb_register_file_unit.sv
// Bench for register_file_unit: table of directed vectors on the default
// configuration, plus hand sequences for mid-cycle reset and a DW=4/NREG=4 wrap.
module tb_register_file_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default instance: DW=8, NREG=8
    logic [7:0]  ld_en, sel_en;
    logic [1:0]  pair_idx;
    logic        ld_pair, sel_pair, inc_pair, err_clear;
    logic [7:0]  data_in, data_out;
    logic        data_oe, addr_oe, inc_wrap, err;
    logic [15:0] addr_in, addr_out;
    logic [63:0] regs;

    register_file_unit u_dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .sel_en(sel_en),
        .pair_idx(pair_idx), .ld_pair(ld_pair), .sel_pair(sel_pair),
        .inc_pair(inc_pair), .data_bus_in(data_in), .data_bus_out(data_out),
        .data_bus_oe(data_oe), .addr_bus_in(addr_in), .addr_bus_out(addr_out),
        .addr_bus_oe(addr_oe), .inc_wrap(inc_wrap), .err_contention(err),
        .err_clear(err_clear), .regs_q(regs)
    );

    // Small instance: DW=4, NREG=4
    logic [3:0]  ld_en4, sel_en4;
    logic [0:0]  pair_idx4;
    logic        ld_pair4, sel_pair4, inc_pair4, err_clear4;
    logic [3:0]  data_in4, data_out4;
    logic        data_oe4, addr_oe4, inc_wrap4, err4;
    logic [7:0]  addr_in4, addr_out4;
    logic [15:0] regs4;

    register_file_unit #(.DW(4), .NREG(4)) u_small (
        .clk(clk), .reset(reset), .ld_en(ld_en4), .sel_en(sel_en4),
        .pair_idx(pair_idx4), .ld_pair(ld_pair4), .sel_pair(sel_pair4),
        .inc_pair(inc_pair4), .data_bus_in(data_in4), .data_bus_out(data_out4),
        .data_bus_oe(data_oe4), .addr_bus_in(addr_in4), .addr_bus_out(addr_out4),
        .addr_bus_oe(addr_oe4), .inc_wrap(inc_wrap4), .err_contention(err4),
        .err_clear(err_clear4), .regs_q(regs4)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  ld_en;
        logic [7:0]  sel_en;
        logic [1:0]  pidx;
        logic        ld_pair;
        logic        sel_pair;
        logic        inc_pair;
        logic        err_clear;
        logic [7:0]  din;
        logic [15:0] ain;
        logic [7:0]  e_dout;   // pre-edge, combinational
        logic        e_doe;
        logic [15:0] e_aout;
        logic        e_aoe;
        logic        e_wrap;   // post-edge, registered
        logic        e_err;
        logic [63:0] e_regs;
    } vec_t;

    localparam int NV = 19;
    vec_t v [NV];

    initial begin
        // ld_en   sel_en  idx   ldp   selp  inc   clr   din     ain       dout   doe   aout      aoe   wrap  err   regs (reg7..reg0)
        v[0]  = '{8'h08, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h00000000_A5000000};
        v[1]  = '{8'h00, 8'h08, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'hA5, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h00000000_A5000000};
        v[2]  = '{8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h12FF, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h00000000_FF120000};
        v[3]  = '{8'h00, 8'h00, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h12FF, 1'b1, 1'b0, 1'b0, 64'h00000000_00130000};
        v[4]  = '{8'h00, 8'h00, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h1300, 1'b1, 1'b0, 1'b0, 64'h00000000_00130000};
        v[5]  = '{8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFF, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h00000000_FFFF0000};
        v[6]  = '{8'h00, 8'h00, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 64'h00000000_00000000};
        v[7]  = '{8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h00000000_00000000};
        v[8]  = '{8'h02, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h00000000_00003C00};
        v[9]  = '{8'h00, 8'h06, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h3C, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 64'h00000000_00003C00};
        v[10] = '{8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 64'h00000000_00003C00};
        v[11] = '{8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h00000000_00003C00};
        v[12] = '{8'h01, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 16'hBEEF, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 64'h00000000_0000EFBE};
        v[13] = '{8'h00, 8'h03, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 8'hBE, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 64'h00000000_0000EFBE};
        v[14] = '{8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h00000000_0000EFBE};
        v[15] = '{8'h80, 8'h80, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h77000000_0000EFBE};
        v[16] = '{8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h78000000_0000EFBE};
        v[17] = '{8'h04, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h78000000_0055F0BE};
        v[18] = '{8'h02, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 64'h78000000_0055F1BE};

        ld_en = '0; sel_en = '0; pair_idx = '0; ld_pair = 1'b0; sel_pair = 1'b0;
        inc_pair = 1'b0; err_clear = 1'b0; data_in = '0; addr_in = '0;
        ld_en4 = '0; sel_en4 = '0; pair_idx4 = '0; ld_pair4 = 1'b0; sel_pair4 = 1'b0;
        inc_pair4 = 1'b0; err_clear4 = 1'b0; data_in4 = '0; addr_in4 = '0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_regs", 64'(regs), 64'h0);
        check("reset_wrap", 64'(inc_wrap), 64'h0);
        check("reset_err",  64'(err), 64'h0);
        check("reset_regs4", 64'(regs4), 64'h0);

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            ld_en = v[k].ld_en; sel_en = v[k].sel_en; pair_idx = v[k].pidx;
            ld_pair = v[k].ld_pair; sel_pair = v[k].sel_pair; inc_pair = v[k].inc_pair;
            err_clear = v[k].err_clear; data_in = v[k].din; addr_in = v[k].ain;
            #1;
            check($sformatf("v%0d_dout", k), 64'(data_out), 64'(v[k].e_dout));
            check($sformatf("v%0d_doe",  k), 64'(data_oe),  64'(v[k].e_doe));
            check($sformatf("v%0d_aout", k), 64'(addr_out), 64'(v[k].e_aout));
            check($sformatf("v%0d_aoe",  k), 64'(addr_oe),  64'(v[k].e_aoe));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_wrap", k), 64'(inc_wrap), 64'(v[k].e_wrap));
            check($sformatf("v%0d_err",  k), 64'(err),      64'(v[k].e_err));
            check($sformatf("v%0d_regs", k), regs,          v[k].e_regs);
        end

        // Reset asserted between edges with selects active: state and enables drop at once.
        @(negedge clk);
        ld_en = 8'hFF; data_in = 8'h5A; sel_en = 8'hFF; sel_pair = 1'b1;
        pair_idx = 2'd0; ld_pair = 1'b0; inc_pair = 1'b0; err_clear = 1'b0;
        #1;
        check("pre_reset_aoe", 64'(addr_oe), 64'h1);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_regs", regs, 64'h0);
        check("midreset_doe", 64'(data_oe), 64'h0);
        check("midreset_aoe", 64'(addr_oe), 64'h0);
        check("midreset_err", 64'(err), 64'h0);
        ld_en = '0; sel_en = '0; sel_pair = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("postreset_regs", regs, 64'h0);

        // Small instance: pair 1 = 0xFF, increment wraps to 0x00 with a one-cycle pulse.
        @(negedge clk);
        pair_idx4 = 1'b1; ld_pair4 = 1'b1; addr_in4 = 8'hFF;
        @(posedge clk);
        #1;
        check("s_load_regs", 64'(regs4), 64'h0000_0000_0000_FF00);
        @(negedge clk);
        ld_pair4 = 1'b0; inc_pair4 = 1'b1; sel_pair4 = 1'b1;
        #1;
        check("s_aout_ff", 64'(addr_out4), 64'hFF);
        @(posedge clk);
        #1;
        check("s_inc_regs", 64'(regs4), 64'h0);
        check("s_wrap", 64'(inc_wrap4), 64'h1);
        @(negedge clk);
        inc_pair4 = 1'b0; ld_pair4 = 1'b1; addr_in4 = 8'hA7;
        @(posedge clk);
        #1;
        check("s_wrap_gone", 64'(inc_wrap4), 64'h0);
        check("s_aout_a7", 64'(addr_out4), 64'hA7);
        check("s_regs_a7", 64'(regs4), 64'h0000_0000_0000_7A00);
        @(negedge clk);
        ld_pair4 = 1'b0; sel_pair4 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file_unit.md
# register_file_unit

Parametrised, clocked successor to the relay-computer register unit. Holds `NREG` general registers of `DW` bits each, organised as `NREG/2` high/low pairs. Drives the shared data bus from one selected register and the address bus from one selected pair. Loads single registers or whole pairs on the clock edge, increments a pair in place (XY/PC style), and latches bus-contention errors. Sits between the sequencer's control decode and the data/address buses.

## Interface
Parameters:
- `DW`, default 8: register and data-bus width.
- `NREG`, default 8: register count. Must be even and ≥ 2.
- `AW`: address width, fixed at 2*DW. Not overridable.
- `PW`: pair-index width, max(1, clog2(NREG/2)). Derived.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ld_en`  in  NREG  bit i loads register i from `data_bus_in`.
- `sel_en`  in  NREG  bit i drives register i onto the data bus.
- `pair_idx`  in  PW  pair p = {reg[2p] (high), reg[2p+1] (low)}.
- `ld_pair`  in  1  loads pair `pair_idx` from `addr_bus_in`.
- `sel_pair`  in  1  drives pair `pair_idx` onto the address bus.
- `inc_pair`  in  1  increments pair `pair_idx` by 1.
- `data_bus_in`  in  DW  data bus as seen at the pins.
- `data_bus_out`  out  DW  value driven onto the data bus.
- `data_bus_oe`  out  1  data-bus drive enable.
- `addr_bus_in`  in  AW  address bus as seen at the pins.
- `addr_bus_out`  out  AW  value driven onto the address bus.
- `addr_bus_oe`  out  1  address-bus drive enable.
- `inc_wrap`  out  1  one-cycle pulse: the last increment wrapped to 0.
- `err_contention`  out  1  sticky error flag.
- `err_clear`  in  1  synchronous clear of `err_contention`.
- `regs_q`  out  NREG*DW  flat view of all registers; register i at bits [i*DW +: DW].

## Operation
- Data-bus drive is combinational.
  - `data_bus_oe` = |sel_en.
  - `data_bus_out` = register at the lowest set index of `sel_en`; 0 when none is set.
- Address-bus drive is combinational.
  - `addr_bus_oe` = `sel_pair`.
  - `addr_bus_out` = {reg[2p], reg[2p+1]}; 0 when `sel_pair` is low.
- Per-register write priority at the clock edge, highest first:
  1. `ld_pair` (target pair)
  2. `inc_pair` (target pair)
  3. `ld_en[i]`
- A load with its own register selected (for example `ld_en[i]` and `sel_en[i]` together) captures `data_bus_in` as seen at the pins. No internal bypass.
- Increment: {hi,lo} ← ({hi,lo}+1) mod 2^AW. Carry propagates from the low to the high register. 0xFFFF→0x0000 at DW=8.
- `inc_wrap` is registered. It is 1 for exactly the cycle after an increment that actually executed (not overridden by `ld_pair`) and produced 0.
- `err_contention` is set at the edge if any of the following held in that cycle:
  - more than one `sel_en` bit is set;
  - `ld_pair` and `inc_pair` are both set;
  - `ld_pair` or `inc_pair` is set while `ld_en` hits either register of the same pair.
- A contention event does not block the operation. Priority rules still apply.
- `err_clear` clears `err_contention`. If a new contention occurs in the same cycle, set wins.
- Registers, pair selection and priority all follow `pair_idx` sampled in the current cycle.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - all registers = 0, `inc_wrap` = 0, `err_contention` = 0;
  - `data_bus_oe` = 0 and `addr_bus_oe` = 0 are forced while `reset` is high, regardless of selects.
- Reset asserted mid-operation aborts any pending load or increment. All state is 0 immediately, no edge required.
- Load latency: one edge. The value is visible on `regs_q` and on the buses after that edge.
- Select latency: zero cycles (combinational from `sel_*` and register state).
- Back-to-back increments every cycle are legal. Each one advances the pair by exactly 1.
- With no control asserted, all state holds indefinitely.

## Test plan
- Reset, then `ld_en[3]` with `data_bus_in`=0xA5 for one cycle, then `sel_en[3]` → `data_bus_out`=0xA5, `data_bus_oe`=1, `regs_q[31:24]`=0xA5.
- `ld_pair` with `pair_idx`=1 and `addr_bus_in`=0x12FF; then `inc_pair` → reg2=0x13, reg3=0x00. Repeat with 0xFFFF → pair reads 0x0000 and `inc_wrap`=1 for one cycle only.
- `sel_en`=0b0000_0110 → `data_bus_out`=reg1, `err_contention`=1 after the edge. Assert `err_clear` with no contention → flag returns to 0.
- In the same cycle, `ld_pair`(idx 0, 0xBEEF), `inc_pair` and `ld_en[0]`(0x11) → pair 0 = 0xBEEF, `err_contention`=1, `inc_wrap`=0.
- Registers loaded with non-zero values and `sel_pair`=1; assert `reset` between clock edges → all `regs_q`=0 and both `oe`=0 immediately. After release, the old values are gone.
- Run with `DW`=4, `NREG`=4: pair 1 at 0xFF, then `inc_pair` → 0x00 with a wrap pulse. `addr_bus_out` is 8 bits wide.
